huffman_input_packer: RTL and testbench

Upstream feeder for huffman_encoder_v5. It accepts a byte stream from the source or LZ4 stage and packs it big-endian into 32-bit words (first byte in [31:24]). It drives the encoder's start, in_valid, stat_end, in_end and last_mask protocol in hardware, and reports the original frame length so the frame length field can be written at byte offset 4 of the output.

---
 rtl/huffman_pkg.sv | 19 +
 rtl/huffman_byte_packer.sv | 107 ++++++++++
 rtl/huffman_input_packer.sv | 143 ++++++++++++++
 tb/tb_huffman_input_packer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman input packer: FSM states, word geometry
// and default frame parameters.
package huffman_pkg;

  localparam int STAT_LEN_DEFAULT = 8192;
  localparam int LEN_W_DEFAULT    = 32;
  localparam int MASK_W           = 3;
  localparam int BYTE_W           = 8;
  localparam int WORD_W           = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    ACTIVE = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/huffman_byte_packer.sv
// Big-endian byte-to-word assembly register. A completing word is offered
// combinationally so it can reach the output register in the same cycle.
module huffman_byte_packer
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  input  logic              stat_mark,
  input  logic              take,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_data,
  output logic [MASK_W-1:0] word_cnt,
  output logic              word_last,
  output logic              word_mark,
  output logic              held
);

  logic [WORD_W-1:0] data_p0;
  logic [1:0]        idx_p0;
  logic [MASK_W-1:0] cnt_p0;
  logic              full_p0;
  logic              last_p0;
  logic              mark_p0;

  logic [WORD_W-1:0] base_data;
  logic [WORD_W-1:0] ins_data;
  logic [1:0]        base_idx;
  logic [4:0]        shamt;
  logic [MASK_W-1:0] ins_cnt;
  logic              base_mark;
  logic              ins_mark;
  logic              done;

  // A held (complete) word leaves this cycle whenever a byte is accepted, so
  // the incoming byte always starts a fresh word in that case.
  always_comb begin
    base_data = full_p0 ? '0 : data_p0;
    base_idx  = full_p0 ? 2'd0 : idx_p0;
    base_mark = full_p0 ? 1'b0 : mark_p0;
    shamt     = {base_idx, 3'b000};
    ins_data  = base_data | ({s_data, {(WORD_W-BYTE_W){1'b0}}} >> shamt);
    ins_cnt   = {1'b0, base_idx} + 3'd1;
    ins_mark  = base_mark | stat_mark;
    done      = accept && ((base_idx == 2'd3) || s_last);
  end

  always_comb begin
    held = full_p0;
    if (full_p0) begin
      word_vld  = 1'b1;
      word_data = data_p0;
      word_cnt  = cnt_p0;
      word_last = last_p0;
      word_mark = mark_p0;
    end else begin
      word_vld  = done;
      word_data = ins_data;
      word_cnt  = ins_cnt;
      word_last = s_last;
      word_mark = ins_mark;
    end
  end

  // Stage p0: assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
      idx_p0  <= '0;
      cnt_p0  <= '0;
      full_p0 <= 1'b0;
      last_p0 <= 1'b0;
      mark_p0 <= 1'b0;
    end else begin
      if (full_p0 && take) begin
        full_p0 <= 1'b0;
        data_p0 <= '0;
        idx_p0  <= '0;
        cnt_p0  <= '0;
        last_p0 <= 1'b0;
        mark_p0 <= 1'b0;
      end
      if (accept) begin
        if (done) begin
          idx_p0 <= 2'd0;
          if (!full_p0 && take) begin
            data_p0 <= '0;
            mark_p0 <= 1'b0;
          end else begin
            full_p0 <= 1'b1;
            data_p0 <= ins_data;
            cnt_p0  <= ins_cnt;
            last_p0 <= s_last;
            mark_p0 <= ins_mark;
          end
        end else begin
          data_p0 <= ins_data;
          idx_p0  <= base_idx + 2'd1;
          mark_p0 <= ins_mark;
        end
      end
    end
  end

endmodule

// File: rtl/huffman_input_packer.sv
// Packs a byte stream into 32-bit big-endian words and drives the Huffman
// encoder's start / in_valid / stat_end / in_end / last_mask handshake.
module huffman_input_packer
  import huffman_pkg::*;
#(
  parameter int STAT_LEN = STAT_LEN_DEFAULT,
  parameter int LEN_W    = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              frame_start,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              h_start,
  output logic [WORD_W-1:0] h_data,
  output logic              h_valid,
  input  logic              h_full,
  output logic              h_stat_end,
  output logic              h_end,
  output logic [MASK_W-1:0] h_last_mask,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_len_valid,
  output logic              busy
);

  state_t state_p;
  state_t state_nxt;

  logic              srst;
  logic              start_ok;
  logic              out_free;
  logic              xfer;
  logic              final_xfer;
  logic              take;
  logic              accept;
  logic              stat_mark;

  logic              word_vld;
  logic [WORD_W-1:0] word_data;
  logic [MASK_W-1:0] word_cnt;
  logic              word_last;
  logic              word_mark;
  logic              held;

  logic              out_vld_p1;
  logic [WORD_W-1:0] out_data_p1;
  logic              out_last_p1;

  assign srst       = rst | clear;
  assign start_ok   = frame_start && ((state_p == IDLE) || (state_p == DONE));
  assign out_free   = !out_vld_p1 || !h_full;
  assign xfer       = out_vld_p1 && !h_full;
  assign final_xfer = xfer && out_last_p1;
  assign take       = word_vld && out_free;
  assign accept     = s_valid && s_ready;
  assign stat_mark  = (frame_len == LEN_W'(STAT_LEN - 1));
  assign h_valid    = out_vld_p1;
  assign h_data     = out_data_p1;

  huffman_byte_packer u_packer (
    .clk       (clk),
    .rst       (srst),
    .accept    (accept),
    .s_data    (s_data),
    .s_last    (s_last),
    .stat_mark (stat_mark),
    .take      (take),
    .word_vld  (word_vld),
    .word_data (word_data),
    .word_cnt  (word_cnt),
    .word_last (word_last),
    .word_mark (word_mark),
    .held      (held)
  );

  always_ff @(posedge clk) begin
    if (srst) state_p <= IDLE;
    else      state_p <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p;
    case (state_p)
      IDLE:    if (start_ok) state_nxt = START;
      START:   state_nxt = ACTIVE;
      ACTIVE:  if (accept && s_last) state_nxt = FLUSH;
      FLUSH:   if (final_xfer) state_nxt = DONE;
      DONE:    if (start_ok) state_nxt = START;
      default: state_nxt = IDLE;
    endcase
  end

  // A byte is refused only while a complete word waits behind a blocked output.
  always_comb begin
    h_start = (state_p == START);
    busy    = (state_p == START) || (state_p == ACTIVE) || (state_p == FLUSH);
    s_ready = (state_p == ACTIVE) && !(held && !out_free);
  end

  // Stage p1: output word register
  always_ff @(posedge clk) begin
    if (srst) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else if (take) begin
      out_vld_p1  <= 1'b1;
      out_data_p1 <= word_data;
      out_last_p1 <= word_last;
    end else if (xfer) begin
      out_vld_p1  <= 1'b0;
    end
  end

  // Frame status: cleared on entry to START, latched as the frame ends.
  always_ff @(posedge clk) begin
    if (srst) begin
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      h_stat_end      <= 1'b0;
      h_end           <= 1'b0;
      h_last_mask     <= '0;
    end else if (start_ok) begin
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      h_stat_end      <= 1'b0;
      h_end           <= 1'b0;
      h_last_mask     <= '0;
    end else begin
      if (accept) frame_len <= frame_len + LEN_W'(1);
      if (take && (word_mark || word_last)) h_stat_end <= 1'b1;
      if (take && word_last) begin
        h_end       <= 1'b1;
        h_last_mask <= word_cnt;
      end
      if ((state_p == FLUSH) && final_xfer) frame_len_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_input_packer.sv
// Self-checking bench: byte-level scoreboard model plus table-driven frames
// and hand-written sequences for stall, clear and ignored frame_start.
module tb_huffman_input_packer;
  import huffman_pkg::*;

  localparam int STAT_LEN = 8192;
  localparam int LEN_W    = 32;

  logic        clk = 1'b0;
  logic        rst, clear, frame_start, s_valid, s_last;
  logic [7:0]  s_data;
  logic        s_ready, h_start, h_valid, h_stat_end, h_end, frame_len_valid, busy;
  logic        h_full = 1'b0;
  logic [31:0] h_data;
  logic [2:0]  h_last_mask;
  logic [LEN_W-1:0] frame_len;

  always #5 clk = ~clk;

  huffman_input_packer #(.STAT_LEN(STAT_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .frame_start(frame_start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .h_start(h_start), .h_data(h_data), .h_valid(h_valid), .h_full(h_full),
    .h_stat_end(h_stat_end), .h_end(h_end), .h_last_mask(h_last_mask),
    .frame_len(frame_len), .frame_len_valid(frame_len_valid), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  mask;
    logic        stat;
  } wrd_t;

  typedef struct {
    int          len;
    int          stall;
    logic [31:0] exp_len;
    logic [2:0]  exp_mask;
    int          exp_words;
  } vec_t;

  wrd_t exp_q[$];
  wrd_t got_q[$];
  vec_t vecs[8];

  int   checks = 0;
  int   errors = 0;
  int   stall_pct = 0;
  int   start_cnt = 0;
  int   acc_cnt = 0;
  int   stall_viol = 0;
  int   sb_rd = 0;
  bit   aborted = 1'b0;
  int   hold_acc;
  logic hold_rdy;

  logic [31:0] m_word = '0;
  logic [31:0] prev_data = '0;
  int          m_idx = 0;
  int          m_cnt = 0;
  logic        m_mark = 1'b0;
  logic        m_stat = 1'b0;
  logic        m_in = 1'b0;
  logic        prev_stall = 1'b0;

  // Encoder back-pressure generator.
  always begin
    @(posedge clk);
    #1;
    h_full = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
  end

  // Reference model: packs accepted bytes into expected words and logs transfers.
  always @(negedge clk) begin
    if (rst || clear) begin
      m_word = '0; m_idx = 0; m_cnt = 0; m_mark = 1'b0; m_stat = 1'b0;
      m_in = 1'b0; prev_stall = 1'b0;
    end else begin
      if (h_start) start_cnt++;
      if (frame_start && !m_in) begin
        m_in = 1'b1; m_cnt = 0; m_stat = 1'b0; m_word = '0; m_idx = 0; m_mark = 1'b0;
      end
      if (s_valid && s_ready) begin
        acc_cnt++;
        m_word[31-8*m_idx -: 8] = s_data;
        if (m_cnt == STAT_LEN - 1) m_mark = 1'b1;
        m_cnt++;
        m_idx++;
        if (m_idx == 4 || s_last) begin
          m_stat = m_stat | m_mark | s_last;
          exp_q.push_back('{data: m_word, last: s_last,
                            mask: s_last ? 3'(m_idx) : 3'd0, stat: m_stat});
          m_word = '0; m_idx = 0; m_mark = 1'b0;
        end
      end
      if (prev_stall && (!h_valid || h_data !== prev_data)) stall_viol++;
      if (h_valid && !h_full) begin
        got_q.push_back('{data: h_data, last: h_end, mask: h_last_mask, stat: h_stat_end});
        if (h_end) m_in = 1'b0;
      end
      prev_stall = h_valid && h_full;
      prev_data  = h_data;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    if (aborted) return;
    s_data = d; s_valid = 1'b1; s_last = l;
    @(negedge clk);
    while (!s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      aborted = 1'b1;
      chk("byte_accept", s_ready, 1);
      s_valid = 1'b0; s_last = 1'b0;
      return;
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit rnd, input int base);
    pulse_start();
    for (int i = 0; i < len; i++)
      drive_byte(rnd ? 8'($urandom) : 8'(base + i), i == len - 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!frame_len_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done", frame_len_valid, 1);
    tick();
  endtask

  task automatic sb_check(input string nm);
    int bad;
    bad = 0;
    chk({nm, "_word_count"}, got_q.size(), exp_q.size());
    for (int i = sb_rd; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({nm, "_scoreboard"}, bad, 0);
    sb_rd = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
  endtask

  initial begin
    int g0, s0, a0;
    vecs[0] = '{1,  0,  32'd1,  3'd1, 1};
    vecs[1] = '{2,  0,  32'd2,  3'd2, 1};
    vecs[2] = '{3,  20, 32'd3,  3'd3, 1};
    vecs[3] = '{4,  0,  32'd4,  3'd4, 1};
    vecs[4] = '{5,  50, 32'd5,  3'd1, 2};
    vecs[5] = '{8,  30, 32'd8,  3'd4, 2};
    vecs[6] = '{9,  0,  32'd9,  3'd1, 3};
    vecs[7] = '{13, 40, 32'd13, 3'd1, 4};

    rst = 1'b1; clear = 1'b0; frame_start = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    chk("rst_h_valid", h_valid, 0);
    chk("rst_h_data", h_data, 0);
    chk("rst_h_last_mask", h_last_mask, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("idle_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_h_end", h_end, 0);
    chk("rst_h_stat_end", h_stat_end, 0);
    chk("rst_frame_len_valid", frame_len_valid, 0);
    chk("rst_h_start", h_start, 0);
    tick();
    s_valid = 1'b0;
    chk("idle_no_accept", acc_cnt, 0);

    // Nine bytes 0x01..0x09 without stalls.
    g0 = got_q.size(); s0 = start_cnt;
    send_frame(9, 1'b0, 1);
    wait_done();
    chk("t1_words", got_q.size() - g0, 3);
    chk("t1_w0", got_q[g0].data, 32'h01020304);
    chk("t1_w1", got_q[g0+1].data, 32'h05060708);
    chk("t1_w2", got_q[g0+2].data, 32'h09000000);
    chk("t1_w1_end", got_q[g0+1].last, 0);
    chk("t1_w2_end", got_q[g0+2].last, 1);
    chk("t1_w2_mask", got_q[g0+2].mask, 1);
    chk("t1_w2_stat", got_q[g0+2].stat, 1);
    chk("t1_frame_len", frame_len, 9);
    chk("t1_frame_len_valid", frame_len_valid, 1);
    chk("t1_busy", busy, 0);
    chk("t1_h_end_hold", h_end, 1);
    chk("t1_mask_hold", h_last_mask, 1);
    chk("t1_h_valid_done", h_valid, 0);
    chk("t1_starts", start_cnt - s0, 1);
    sb_check("t1");
    s_valid = 1'b1;
    @(negedge clk);
    chk("done_s_ready", s_ready, 0);
    tick();
    s_valid = 1'b0;

    for (int k = 0; k < 8; k++) begin
      stall_pct = vecs[k].stall;
      g0 = got_q.size();
      send_frame(vecs[k].len, 1'b0, 16 * k + 32);
      wait_done();
      stall_pct = 0;
      chk($sformatf("vec%0d_frame_len", k), frame_len, vecs[k].exp_len);
      chk($sformatf("vec%0d_mask", k), h_last_mask, vecs[k].exp_mask);
      chk($sformatf("vec%0d_h_end", k), h_end, 1);
      chk($sformatf("vec%0d_words", k), got_q.size() - g0, vecs[k].exp_words);
      sb_check($sformatf("vec%0d", k));
    end

    // Exactly STAT_LEN bytes: stat_end arrives with the final word.
    g0 = got_q.size();
    send_frame(8192, 1'b0, 0);
    wait_done();
    chk("t8k_words", got_q.size() - g0, 2048);
    chk("t8k_w2046_stat", got_q[g0+2046].stat, 0);
    chk("t8k_w2047_stat", got_q[g0+2047].stat, 1);
    chk("t8k_w2047_data", got_q[g0+2047].data, 32'hFCFDFEFF);
    chk("t8k_w2047_mask", got_q[g0+2047].mask, 4);
    chk("t8k_frame_len", frame_len, 8192);
    sb_check("t8k");

    // Long random frame under random back-pressure.
    stall_pct = 30;
    send_frame(12000, 1'b1, 0);
    wait_done();
    stall_pct = 0;
    chk("rnd_frame_len", frame_len, 32'h2EE0);
    chk("rnd_mask", h_last_mask, 4);
    chk("rnd_stall_stable", stall_viol, 0);
    sb_check("rnd");

    // Sustained h_full with s_valid held high.
    stall_pct = 100;
    tick(); tick();
    pulse_start();
    a0 = acc_cnt;
    fork
      for (int i = 0; i < 30; i++) drive_byte(8'(8'h40 + i), i == 29);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        hold_acc = acc_cnt - a0;
        hold_rdy = s_ready;
        stall_pct = 0;
      end
    join
    wait_done();
    chk("hold_max8", hold_acc <= 8, 1);
    chk("hold_progress", hold_acc > 0, 1);
    chk("hold_ready_low", hold_rdy, 0);
    chk("hold_frame_len", frame_len, 30);
    chk("hold_stall_stable", stall_viol, 0);
    sb_check("hold");

    // clear mid-frame, then a short frame.
    s0 = start_cnt;
    pulse_start();
    for (int i = 0; i < 6; i++) drive_byte(8'(8'h60 + i), 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_h_valid", h_valid, 0);
    chk("clr_frame_len", frame_len, 0);
    chk("clr_busy", busy, 0);
    tick();
    sb_check("pre_clear");
    g0 = got_q.size();
    pulse_start();
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    drive_byte(8'hCC, 1'b1);
    wait_done();
    chk("clr_words", got_q.size() - g0, 1);
    chk("clr_word", got_q[g0].data, 32'hAABBCC00);
    chk("clr_word_mask", got_q[g0].mask, 3);
    chk("clr_frame_len", frame_len, 3);
    chk("clr_starts", start_cnt - s0, 2);
    sb_check("clr");

    // frame_start during ACTIVE has no effect.
    s0 = start_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) drive_byte(8'(8'h70 + i), 1'b0);
    pulse_start();
    drive_byte(8'h73, 1'b0);
    drive_byte(8'h74, 1'b1);
    wait_done();
    chk("ign_starts", start_cnt - s0, 1);
    chk("ign_frame_len", frame_len, 5);
    chk("ign_mask", h_last_mask, 1);
    sb_check("ign");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
